msrv32_redirect_ctrl: RTL
=========================

# msrv32_redirect_ctrl

Sequences control-flow redirects for the RV32 pipeline. It consumes the execute-stage branch decision (`branch_taken_in`), JAL/JALR opcodes and trap requests, and computes the redirect target. It then runs a request/acknowledge handshake with fetch and flushes the younger stages for a programmable number of cycles. Execute is held off while a redirect is in flight, and redirects are counted for performance monitoring.

## Interface
- `FLUSH_CYCLES`, default 2: flush cycles after fetch accepts a redirect (0..15).
- `CNT_W`, default 16: width of the saturating redirect counter.

- `clk_in`  in  1  clock; all state updates on rising edge.
- `rst_n_in`  in  1  reset, synchronous, active-low.
- `ex_valid_in`  in  1  execute stage holds a valid instruction.
- `ex_ready_out`  out  1  instruction accepted this cycle. Equals 1 only in IDLE with no trap.
- `opcode_in`  in  5  instr[6:2] of the execute instruction.
- `branch_taken_in`  in  1  conditional-branch decision from the branch unit.
- `pc_in`  in  32  PC of the execute instruction.
- `imm_in`  in  32  sign-extended immediate.
- `rs_1_in`  in  32  rs1 value (JALR base).
- `trap_in`  in  1  trap request. Level-sampled every cycle.
- `trap_vector_in`  in  32  trap handler address.
- `redirect_valid_out`  out  1  redirect request to fetch.
- `redirect_pc_out`  out  32  redirect target.
- `redirect_ready_in`  in  1  fetch accepts the redirect.
- `flush_out`  out  1  kill IF/ID contents.
- `misaligned_out`  out  1  one-cycle pulse on an instruction-address-misaligned target.
- `misaligned_addr_out`  out  32  offending target, held until the next pulse.
- `redirect_count_out`  out  CNT_W  completed redirects, saturating.

## Operation
- Redirect need, evaluated only when an instruction is accepted (IDLE, `ex_valid_in=1`):
  - JAL (`opcode_in=11011`): target = `pc_in + imm_in`.
  - JALR (`11001`): target = (`rs_1_in + imm_in`) with bit0 forced to 0.
  - Conditional branch (`11000` with `branch_taken_in=1`): target = `pc_in + imm_in`.
  - All other cases: no redirect, no state change.
- All arithmetic is 32-bit modulo 2^32; carry is discarded.
- Misalignment: target[1]=1 (no C extension) means no redirect is issued. `misaligned_out` pulses the next cycle, `misaligned_addr_out` is loaded, and the FSM stays in IDLE.
- Priority: `trap_in` beats any execute redirect in the same cycle. Trap targets are never checked for misalignment.
- FSM states: IDLE, REQ, FLUSH.
  - IDLE to REQ: `trap_in`, or an accepted aligned redirect. The target is latched into `redirect_pc_out`.
  - REQ to FLUSH: `redirect_ready_in=1` while `redirect_valid_out=1`. `redirect_count_out` increments (saturating at all ones).
  - REQ to IDLE: same condition, when `FLUSH_CYCLES=0`.
  - FLUSH to IDLE: after `FLUSH_CYCLES` cycles in FLUSH, tracked by a down-counter.
  - Trap in REQ: `redirect_pc_out` is replaced by `trap_vector_in` and the FSM stays in REQ. If the trap and `redirect_ready_in` occur in the same cycle, the trap wins: no acceptance and no count.
  - Trap in FLUSH: return to REQ with `trap_vector_in`; the flush counter is discarded.
- Outputs by state:
  - `redirect_valid_out` = (state==REQ).
  - `flush_out` = (state==REQ or FLUSH).
  - `ex_ready_out` = (state==IDLE and `trap_in`=0).
- `redirect_pc_out` is stable while `redirect_valid_out=1`, except on a trap replacement.

## Timing
- Reset values when `rst_n_in=0` at an edge:
  - state IDLE and flush counter 0.
  - `redirect_valid_out`, `flush_out` and `misaligned_out` = 0.
  - `ex_ready_out` = 1 (when `trap_in`=0).
  - `redirect_pc_out`, `misaligned_addr_out` and `redirect_count_out` = 0.
- Reset applied mid-REQ or mid-FLUSH aborts the redirect with no count.
- Latency:
  - Acceptance at cycle T gives `redirect_valid_out=1` at T+1.
  - Handshake at cycle H gives FLUSH during H+1 .. H+FLUSH_CYCLES, and IDLE at H+FLUSH_CYCLES+1.
  - Minimum redirect occupancy is FLUSH_CYCLES+2 cycles.
- Fetch may hold `redirect_ready_in` low indefinitely. REQ persists, with `flush_out=1` and `ex_ready_out=0`.
- `redirect_ready_in` outside REQ is ignored.

## Test plan
- BEQ taken: `pc_in=0x100`, `imm_in=0x20`, `branch_taken_in=1`, `ready=1`.
  - `redirect_valid_out=1` with pc 0x120 at T+1.
  - `flush_out` high for 3 cycles.
  - IDLE at T+4; count=1.
- JALR alignment: `rs_1_in=0x2001`, `imm_in=0x4` gives target 0x2004.
  - Redirect issued to 0x2004.
  - Rerun with `imm_in=0x1` (target 0x2002): `misaligned_out` pulses once, addr=0x2002, no redirect, count unchanged.
- Backpressure: `redirect_ready_in=0` for 5 cycles.
  - REQ held with stable pc and `ex_ready_out=0`.
  - Flush begins only after `ready` rises.
- Trap versus redirect:
  - Same cycle as a taken branch (vector 0x80): target is 0x80.
  - Trap during FLUSH: re-enters REQ with 0x80.
  - Trap coinciding with `ready`: no count increment.
- Reset and saturation:
  - `rst_n_in=0` in REQ: all outputs return to reset values next cycle.
  - With `CNT_W=2`: 5 redirects leave the count at 3.

Source files
------------

// File: rtl/msrv32_redirect_ctrl.sv
// Control-flow redirect sequencer for the RV32 pipeline.
// Takes JAL/JALR/taken-branch decisions and traps from execute, drives a
// request/acknowledge handshake toward fetch, then holds a flush window
// of FLUSH_CYCLES cycles before execute may proceed again.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no redirect in flight, execute instructions are accepted
//   ST_REQ   | redirect_pc_out offered to fetch, waiting for ready
//   ST_FLUSH | fetch took the target, younger stages still being killed
module msrv32_redirect_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             ex_valid_in,
    output logic             ex_ready_out,
    input  logic [4:0]       opcode_in,
    input  logic             branch_taken_in,
    input  logic [31:0]      pc_in,
    input  logic [31:0]      imm_in,
    input  logic [31:0]      rs_1_in,
    input  logic             trap_in,
    input  logic [31:0]      trap_vector_in,
    output logic             redirect_valid_out,
    output logic [31:0]      redirect_pc_out,
    input  logic             redirect_ready_in,
    output logic             flush_out,
    output logic             misaligned_out,
    output logic [31:0]      misaligned_addr_out,
    output logic [CNT_W-1:0] redirect_count_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_t           state_q, state_d;
    logic [3:0]       flush_cnt_q, flush_cnt_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic             misaligned_q, misaligned_d;
    logic [31:0]      misaligned_addr_q, misaligned_addr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0] pc_rel_sum;
    logic [31:0] reg_rel_sum;
    logic [31:0] target;
    logic        need_redirect;
    logic        accept;

    assign pc_rel_sum  = pc_in + imm_in;
    assign reg_rel_sum = rs_1_in + imm_in;
    assign accept      = (state_q == ST_IDLE) && ex_valid_in && !trap_in;

    // Decode whether the execute instruction changes control flow, and where to.
    always_comb begin
        need_redirect = 1'b0;
        target        = pc_rel_sum;
        case (opcode_in)
            OP_JAL:    need_redirect = 1'b1;
            OP_JALR: begin
                need_redirect = 1'b1;
                target        = {reg_rel_sum[31:1], 1'b0};
            end
            OP_BRANCH: need_redirect = branch_taken_in;
            default:   need_redirect = 1'b0;
        endcase
    end

    // Next-state logic; a trap always takes precedence over the handshake.
    always_comb begin
        state_d           = state_q;
        flush_cnt_d       = flush_cnt_q;
        redirect_pc_d     = redirect_pc_q;
        count_d           = count_q;
        misaligned_d      = 1'b0;
        misaligned_addr_d = misaligned_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (trap_in) begin
                    state_d       = ST_REQ;
                    redirect_pc_d = trap_vector_in;
                end else if (accept && need_redirect) begin
                    if (target[1]) begin
                        misaligned_d      = 1'b1;
                        misaligned_addr_d = target;
                    end else begin
                        state_d       = ST_REQ;
                        redirect_pc_d = target;
                    end
                end
            end
            ST_REQ: begin
                if (trap_in) begin
                    redirect_pc_d = trap_vector_in;
                end else if (redirect_ready_in) begin
                    if (count_q != {CNT_W{1'b1}}) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (FLUSH_LOAD == 4'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_LOAD;
                    end
                end
            end
            ST_FLUSH: begin
                if (trap_in) begin
                    state_d       = ST_REQ;
                    redirect_pc_d = trap_vector_in;
                    flush_cnt_d   = 4'd0;
                end else if (flush_cnt_q <= 4'd1) begin
                    state_d     = ST_IDLE;
                    flush_cnt_d = 4'd0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                flush_cnt_d = 4'd0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q           <= ST_IDLE;
            flush_cnt_q       <= 4'd0;
            redirect_pc_q     <= 32'd0;
            misaligned_q      <= 1'b0;
            misaligned_addr_q <= 32'd0;
            count_q           <= '0;
        end else begin
            state_q           <= state_d;
            flush_cnt_q       <= flush_cnt_d;
            redirect_pc_q     <= redirect_pc_d;
            misaligned_q      <= misaligned_d;
            misaligned_addr_q <= misaligned_addr_d;
            count_q           <= count_d;
        end
    end

    assign redirect_valid_out  = (state_q == ST_REQ);
    assign flush_out           = (state_q == ST_REQ) || (state_q == ST_FLUSH);
    assign ex_ready_out        = (state_q == ST_IDLE) && !trap_in;
    assign redirect_pc_out     = redirect_pc_q;
    assign misaligned_out      = misaligned_q;
    assign misaligned_addr_out = misaligned_addr_q;
    assign redirect_count_out  = count_q;

endmodule
